// File: rtl/universal_shift_register.sv
// universal_shift_register: N-bit register with load, shift/rotate modes, serial ports and shift counter
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int CW = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);
  logic [WIDTH-1:0] r_q, w_q_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_done, w_is_shift, w_is_restart;
  assign w_is_shift   = (mode != 3'd0) && (mode != 3'd1) && (mode != 3'd7);
  assign w_is_restart = (mode == 3'd1) || (mode == 3'd7);
  // next register value for the selected operation
  always_comb begin
    w_q_next = r_q;
    case (mode)
      3'd1:    w_q_next = d;
      3'd2:    w_q_next = {r_q[WIDTH-2:0], ser_in_lsb};
      3'd3:    w_q_next = {ser_in_msb, r_q[WIDTH-1:1]};
      3'd4:    w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      3'd5:    w_q_next = {r_q[0], r_q[WIDTH-1:1]};
      3'd6:    w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      3'd7:    w_q_next = '0;
      default: w_q_next = r_q;
    endcase
  end
  // counter restarts on load/clear and saturates at WIDTH so done fires only once per run
  always_comb begin
    w_cnt_next = w_is_restart ? '0
               : (w_is_shift && r_cnt < CW'(WIDTH)) ? r_cnt + 1'b1
               : r_cnt;
  end
  // state update: reset wins, enable gates everything, done is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_is_shift && (r_cnt == CW'(WIDTH-1));
    end else begin
      r_done <= 1'b0;
    end
  end
  assign q           = r_q;
  assign shift_cnt   = r_cnt;
  assign done        = r_done;
  assign ser_out_msb = r_q[WIDTH-1];
  assign ser_out_lsb = r_q[0];
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed vectors with a queue scoreboard and a decoupled monitor
module tb_universal_shift_register;
  typedef struct {
    logic [7:0] q;
    logic [3:0] c;
    logic       d;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       ser_in_lsb = 1'b0;
  logic       ser_in_msb = 1'b0;
  logic [7:0] q;
  logic       ser_out_msb, ser_out_lsb;
  logic [3:0] shift_cnt;
  logic       done;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  localparam logic [2:0] H = 3'd0, L = 3'd1, SL = 3'd2, SR = 3'd3, RL = 3'd4, RR = 3'd5, AR = 3'd6, CL = 3'd7;
  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .ser_in_lsb(ser_in_lsb), .ser_in_msb(ser_in_msb), .q(q),
    .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
    .shift_cnt(shift_cnt), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, act, req, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.q));
      chk("shift_cnt", 32'(shift_cnt), 32'(e.c));
      chk("done", 32'(done), 32'(e.d));
      chk("ser_out_msb", 32'(ser_out_msb), 32'(e.q[7]));
      chk("ser_out_lsb", 32'(ser_out_lsb), 32'(e.q[0]));
    end
  end
  task automatic v(input logic r, input logic e, input logic [2:0] m, input logic [7:0] dd,
                   input logic sl, input logic sm, input logic [7:0] eq, input logic [3:0] ec, input logic ed);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; mode = m; d = dd; ser_in_lsb = sl; ser_in_msb = sm;
    x.q = eq; x.c = ec; x.d = ed;
    sb.push_back(x);
  endtask
  initial begin
    v(0, 1, L,  8'hFF, 0, 0, 8'hA5, 0, 0);
    v(1, 1, L,  8'h3C, 0, 0, 8'h3C, 0, 0);
    v(1, 1, L,  8'hB2, 0, 0, 8'hB2, 0, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h64, 1, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'hC8, 2, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h90, 3, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h20, 4, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h40, 5, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h80, 6, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h00, 7, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h00, 8, 1);
    v(1, 1, SL, 8'h00, 0, 0, 8'h00, 8, 0);
    v(1, 1, CL, 8'h00, 0, 0, 8'h00, 0, 0);
    v(1, 1, SR, 8'h00, 0, 1, 8'h80, 1, 0);
    v(1, 1, SR, 8'h00, 0, 1, 8'hC0, 2, 0);
    v(1, 1, SR, 8'h00, 0, 0, 8'h60, 3, 0);
    v(1, 1, SR, 8'h00, 0, 0, 8'h30, 4, 0);
    v(1, 1, SR, 8'h00, 0, 1, 8'h98, 5, 0);
    v(1, 1, SR, 8'h00, 0, 0, 8'h4C, 6, 0);
    v(1, 1, SR, 8'h00, 0, 1, 8'hA6, 7, 0);
    v(1, 1, SR, 8'h00, 0, 0, 8'h53, 8, 1);
    v(1, 1, L,  8'h81, 0, 0, 8'h81, 0, 0);
    v(1, 1, RL, 8'h00, 0, 0, 8'h03, 1, 0);
    v(1, 1, RR, 8'h00, 0, 0, 8'h81, 2, 0);
    v(1, 1, AR, 8'h00, 0, 0, 8'hC0, 3, 0);
    v(1, 1, AR, 8'h00, 0, 0, 8'hE0, 4, 0);
    v(1, 1, H,  8'h00, 0, 0, 8'hE0, 4, 0);
    v(1, 1, L,  8'h0F, 0, 0, 8'h0F, 0, 0);
    for (int i = 0; i < 3; i++) v(1, 0, SL, 8'h00, 1, 0, 8'h0F, 0, 0);
    v(1, 1, SL, 8'h00, 1, 0, 8'h1F, 1, 0);
    v(1, 1, SL, 8'h00, 1, 0, 8'h3F, 2, 0);
    v(1, 1, SL, 8'h00, 1, 0, 8'h7F, 3, 0);
    for (int i = 4; i < 8; i++) v(1, 1, SL, 8'h00, 1, 0, 8'hFF, 4'(i), 0);
    v(1, 0, SL, 8'h00, 1, 0, 8'hFF, 7, 0);
    v(1, 1, SL, 8'h00, 1, 0, 8'hFF, 8, 1);
    v(1, 1, SL, 8'h00, 1, 0, 8'hFF, 8, 0);
    v(1, 1, L,  8'h01, 0, 0, 8'h01, 0, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h02, 1, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h04, 2, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h08, 3, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h10, 4, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h20, 5, 0);
    v(0, 1, SL, 8'h00, 0, 0, 8'hA5, 0, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h4A, 1, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h94, 2, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h28, 3, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h50, 4, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'hA0, 5, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h40, 6, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h80, 7, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h00, 8, 1);
    v(1, 1, SL, 8'h00, 1, 0, 8'h01, 8, 0);
    v(1, 1, L,  8'h81, 0, 0, 8'h81, 0, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h02, 1, 0);
    v(1, 1, SL, 8'h00, 0, 0, 8'h04, 2, 0);
    v(1, 1, CL, 8'hFF, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
